shadow_loader: RTL
==================

SHADOW_LOADER -- requirements
Module: shadow_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles a bus strobe may wait for reg_ready.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-005 The block SHALL have port base_addr, input, 16 bits: first reg-bus word address.
REQ-006 The block SHALL have port word_count, input, 16 bits: number of words to load.
REQ-007 The block SHALL have port verify, input, 1 bit: read back and compare each word after it is written.
REQ-008 The block SHALL have port s_data, input, 32 bits: coefficient stream data.
REQ-009 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 The block SHALL have port s_ready, output, 1 bit: the block accepts s_data.
REQ-011 The block SHALL have ports reg_addr (output, 16 bits), reg_writedata (output, 32 bits), reg_wr (output, 1 bit) and reg_rd (output, 1 bit): reg-bus initiator side.
REQ-012 The block SHALL have ports reg_readdata (input, 32 bits) and reg_ready (input, 1 bit): reg-bus responder return.
REQ-013 The block SHALL have outputs busy (1 bit), done (1 bit, single-cycle pulse), error (1 bit) and err_addr (16 bits).

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_DATA, WRITE, READ and FIN.
REQ-015 In IDLE, start=1 SHALL capture base_addr, word_count and verify, clear error and err_addr, and set busy=1.
- If word_count=0: go to FIN.
- Otherwise: go to WAIT_DATA.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 s_ready SHALL equal 1 only in WAIT_DATA; s_valid&s_ready SHALL latch s_data and move the FSM to WRITE on the next cycle.
REQ-018 WRITE SHALL hold reg_wr=1 with stable reg_addr=current address and reg_writedata=latched word until the cycle in which reg_ready=1 is sampled; the transaction completes in that cycle.
REQ-019 On WRITE completion, the FSM SHALL go to READ if verify=1 and otherwise advance per REQ-021.
REQ-020 READ SHALL hold reg_rd=1 at the same address until reg_ready=1, then compare reg_readdata with the latched word.
- Mismatch: error=1, err_addr=current address, go to FIN.
- Match: advance per REQ-021.
REQ-021 Advance SHALL decrement the remaining count.
- If the count becomes 0: go to FIN.
- Otherwise: address+1 modulo 2^16 (16'hFFFF wraps to 16'h0000), go to WAIT_DATA.
REQ-022 reg_wr and reg_rd SHALL never be 1 in the same cycle, and both SHALL be 0 in the cycle after completion.
REQ-023 A 16-bit wait counter SHALL clear on entry to WRITE or READ; if it reaches TIMEOUT with no reg_ready, the block SHALL drop the strobe, set error=1 and err_addr=current address, and go to FIN.
REQ-024 reg_ready sampled while no strobe is asserted SHALL be ignored.
REQ-025 FIN SHALL assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-026 error and err_addr SHALL hold their values until the next accepted start.
REQ-027 busy SHALL be 1 in WAIT_DATA, WRITE and READ, and 0 in IDLE and FIN.
REQ-028 A stalled stream (s_valid=0) SHALL wait indefinitely in WAIT_DATA without timeout.

Reset
REQ-029 rst=0 SHALL asynchronously force the FSM to IDLE and all outputs, counters and registers to 0, including mid-transaction with a strobe high.
REQ-030 After rst deasserts, the first start SHALL be honoured in the following cycle.

Verification
REQ-031 The bench SHALL cover a basic load: base_addr=16'h0010, count=3, verify=0, data A1/A2/A3, responder with 2-cycle ready latency -> writes at 0010/0011/0012 in order, one done pulse, error=0.
REQ-032 The bench SHALL cover verify with a match: count=2, verify=1, responder echoes written data -> each write is followed by a read at the same address, done, error=0.
REQ-033 The bench SHALL cover verify with a mismatch: the second word reads back 32'hDEADBEEF instead of the written value -> error=1, err_addr=base+1, no third transaction, done pulse.
REQ-034 The bench SHALL cover timeout: TIMEOUT=8, reg_ready held at 0 -> reg_wr drops after 8 cycles, error=1, err_addr=base_addr, done pulse.
REQ-035 The bench SHALL cover wrap and zero count: base_addr=16'hFFFF, count=2 -> writes at FFFF then 0000; count=0 -> done in the cycle after start, no reg_wr.
REQ-036 The bench SHALL cover reset mid-WRITE with s_valid gaps: rst=0 while reg_wr=1 -> all outputs 0 immediately; a new start is accepted afterwards; random s_valid gaps do not change the write order or data.

Source files
------------

// File: rtl/shadow_loader.sv
// Shadow-register loader: drains a 32-bit coefficient stream into consecutive
// reg-bus words, with optional read-back verify and a per-strobe timeout.
module shadow_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        verify,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_writedata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_readdata,
  input  logic        reg_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_addr
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_DATA = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] FIN       = 3'd4;

  // Strobe is held for exactly TIMEOUT cycles before being abandoned.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] addr;
  logic [15:0] remaining;
  logic        verify_q;
  logic [31:0] word_q;
  logic [15:0] wait_cnt;
  logic        error_q;
  logic [15:0] err_addr_q;

  logic accept;
  logic in_write;
  logic in_read;
  logic strobe;
  logic last_word;
  logic wait_expired;
  logic write_done;
  logic read_done;
  logic readback_bad;
  logic advance;
  logic timed_out;
  logic fail_set;
  logic entering_strobe;

  assign accept       = (state == IDLE) && start;
  assign in_write     = (state == WRITE);
  assign in_read      = (state == READ);
  assign strobe       = in_write || in_read;
  assign last_word    = (remaining == 16'd1);
  assign wait_expired = (wait_cnt == WAIT_LIMIT);
  assign write_done   = in_write && reg_ready;
  assign read_done    = in_read && reg_ready;
  assign readback_bad = (reg_readdata != word_q);
  assign advance      = (write_done && !verify_q) || (read_done && !readback_bad);
  assign timed_out    = strobe && !reg_ready && wait_expired;
  assign fail_set     = timed_out || (read_done && readback_bad);

  assign entering_strobe = ((state_next == WRITE) && (state != WRITE)) ||
                           ((state_next == READ)  && (state != READ));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (word_count == 16'd0) ? FIN : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (s_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (reg_ready) begin
          if (verify_q) begin
            state_next = READ;
          end else begin
            state_next = last_word ? FIN : WAIT_DATA;
          end
        end else if (wait_expired) begin
          state_next = FIN;
        end
      end
      READ: begin
        if (reg_ready) begin
          state_next = (readback_bad || last_word) ? FIN : WAIT_DATA;
        end else if (wait_expired) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The address only moves on to the next word when another word follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= 16'd0;
      remaining <= 16'd0;
      verify_q  <= 1'b0;
    end else if (accept) begin
      addr      <= base_addr;
      remaining <= word_count;
      verify_q  <= verify;
    end else if (advance) begin
      remaining <= remaining - 16'd1;
      if (!last_word) begin
        addr <= addr + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= 32'd0;
    end else if ((state == WAIT_DATA) && s_valid) begin
      word_q <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 16'd0;
    end else if (entering_strobe) begin
      wait_cnt <= 16'd0;
    end else if (strobe && !wait_expired) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q    <= 1'b0;
      err_addr_q <= 16'd0;
    end else if (accept) begin
      error_q    <= 1'b0;
      err_addr_q <= 16'd0;
    end else if (fail_set) begin
      error_q    <= 1'b1;
      err_addr_q <= addr;
    end
  end

  assign s_ready       = (state == WAIT_DATA);
  assign reg_wr        = in_write;
  assign reg_rd        = in_read;
  assign reg_addr      = addr;
  assign reg_writedata = word_q;
  assign busy          = (state == WAIT_DATA) || strobe;
  assign done          = (state == FIN);
  assign error         = error_q;
  assign err_addr      = err_addr_q;

endmodule
